// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - stall/flush controller with per-register countdown scoreboard
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   id_valid                   ID stage holds a real instruction
//   id_rs1/id_rs2              source register indices
//   id_use_rs1/id_use_rs2      source is actually read
//   id_regWrite, id_rd         ID instruction writes id_rd
//   ex_branch_taken            branch resolved taken in EXE
//   mem_busy                   data memory not ready, back end frozen
//   stall_front                hold PC and IF/ID
//   flush_ifid                 clear IF/ID on next edge
//   stop_idex                  stop for the ID/EXE register
//   bubble_idex                zero control bits into ID/EXE
//   issue                      ID instruction advances into EXE
//   stall_cause                registered cause: 0 RUN, 1 RAW, 2 MEM, 3 FLUSH
//   stall_count                saturating count of non-RUN cycles
module hazard_stall_ctrl #(
  parameter int NUM_REGS   = 16,
  parameter int WB_LATENCY = 3,
  parameter int CNT_W      = 16,
  localparam int REG_W     = $clog2(NUM_REGS),
  localparam int PEND_W    = $clog2(WB_LATENCY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_regWrite,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             stall_front,
  output logic             flush_ifid,
  output logic             stop_idex,
  output logic             bubble_idex,
  output logic             issue,
  output logic [1:0]       stall_cause,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    CAUSE_RUN   = 2'd0,
    CAUSE_RAW   = 2'd1,
    CAUSE_MEM   = 2'd2,
    CAUSE_FLUSH = 2'd3
  } cause_t;

  cause_t state_q, state_d;

  logic [PEND_W-1:0] pend_q [NUM_REGS];
  logic [CNT_W-1:0]  stall_count_q;
  logic              raw;

  // A register is readable only once its countdown has drained. The ID
  // instruction's own write is not yet in the scoreboard, so reading its
  // own destination never self-stalls.
  always_comb begin
    raw = id_valid &
          ((id_use_rs1 & (pend_q[id_rs1] != '0)) |
           (id_use_rs2 & (pend_q[id_rs2] != '0)));
  end

  always_comb begin
    state_d     = CAUSE_RUN;
    stall_front = 1'b0;
    flush_ifid  = 1'b0;
    stop_idex   = 1'b0;
    bubble_idex = 1'b0;
    issue       = 1'b0;
    if (mem_busy) begin
      state_d     = CAUSE_MEM;
      stall_front = 1'b1;
      stop_idex   = 1'b1;
    end else if (ex_branch_taken) begin
      state_d     = CAUSE_FLUSH;
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else if (raw) begin
      state_d     = CAUSE_RAW;
      stall_front = 1'b1;
      bubble_idex = 1'b1;
    end else begin
      issue       = id_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CAUSE_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Scoreboard: frozen while the back end is held by memory; otherwise
  // every entry drains, and a new issue reloads its destination so the
  // younger writer of a WAW pair wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend_q[r] <= '0;
      end
    end else if (!mem_busy) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (issue && id_regWrite && (id_rd == REG_W'(r))) begin
          pend_q[r] <= PEND_W'(WB_LATENCY);
        end else if (pend_q[r] != '0) begin
          pend_q[r] <= pend_q[r] - PEND_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
    end else if ((state_d != CAUSE_RUN) && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign stall_cause = state_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  localparam int NR  = 16;
  localparam int LAT = 3;
  localparam int CW  = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          id_valid = 1'b0;
  logic [3:0]    id_rs1 = '0;
  logic [3:0]    id_rs2 = '0;
  logic          id_use_rs1 = 1'b0;
  logic          id_use_rs2 = 1'b0;
  logic          id_regWrite = 1'b0;
  logic [3:0]    id_rd = '0;
  logic          ex_branch_taken = 1'b0;
  logic          mem_busy = 1'b0;
  logic          stall_front, flush_ifid, stop_idex, bubble_idex, issue;
  logic [1:0]    stall_cause;
  logic [CW-1:0] stall_count;

  hazard_stall_ctrl #(.NUM_REGS(NR), .WB_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_regWrite(id_regWrite), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .stall_front(stall_front), .flush_ifid(flush_ifid),
    .stop_idex(stop_idex), .bubble_idex(bubble_idex), .issue(issue),
    .stall_cause(stall_cause), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int   compared = 0;
  int   mismatched = 0;
  // Reference: cycles each register still needs before it is readable,
  // last resolved cause, and the saturating stall tally.
  int   rem [NR];
  int   m_cause;
  int   m_count;
  logic last_issue;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) rem[i] = 0;
    m_cause = 0;
    m_count = 0;
  endtask

  task automatic drive(input logic v, input int rs1, input logic u1, input int rs2,
                       input logic u2, input logic wr, input int rd,
                       input logic br, input logic mb);
    id_valid = v; id_rs1 = 4'(rs1); id_use_rs1 = u1; id_rs2 = 4'(rs2);
    id_use_rs2 = u2; id_regWrite = wr; id_rd = 4'(rd);
    ex_branch_taken = br; mem_busy = mb;
  endtask

  // One clock: predict, compare at the falling edge, then advance the model.
  task automatic cycle(input string tag);
    logic raw_m;
    int   cause;
    logic e_issue;
    raw_m = id_valid && ((id_use_rs1 && rem[id_rs1] > 0) || (id_use_rs2 && rem[id_rs2] > 0));
    if (mem_busy)             cause = 2;
    else if (ex_branch_taken) cause = 3;
    else if (raw_m)           cause = 1;
    else                      cause = 0;
    e_issue = (cause == 0) && id_valid;
    @(negedge clk);
    chk({tag, ".stall_front"}, 32'(stall_front), 32'(cause == 1 || cause == 2));
    chk({tag, ".flush_ifid"},  32'(flush_ifid),  32'(cause == 3));
    chk({tag, ".stop_idex"},   32'(stop_idex),   32'(cause == 2));
    chk({tag, ".bubble_idex"}, 32'(bubble_idex), 32'(cause == 1 || cause == 3));
    chk({tag, ".issue"},       32'(issue),       32'(e_issue));
    chk({tag, ".stall_cause"}, 32'(stall_cause), 32'(m_cause));
    chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_count));
    last_issue = issue;
    @(posedge clk);
    if (cause != 2) begin
      for (int i = 0; i < NR; i++) if (rem[i] > 0) rem[i]--;
      if (e_issue && id_regWrite) rem[id_rd] = LAT;
    end
    m_cause = cause;
    if (cause != 0 && m_count < (1 << CW) - 1) m_count++;
    #1;
  endtask

  // Cycles the held ID instruction until it issues; returns bubbles seen.
  task automatic wait_issue(input string tag, output int bubbles);
    bubbles = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(tag);
      if (last_issue) return;
      bubbles++;
    end
    chk({tag, ".timeout"}, 32'(0), 32'(1));
  endtask

  int n;
  int exp_seq [6];

  initial begin
    model_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("reset.stall_cause", 32'(stall_cause), 32'd0);
    chk("reset.stall_count", 32'(stall_count), 32'd0);
    chk("reset.issue", 32'(issue), 32'd1);
    chk("reset.ctrl", {28'd0, stall_front, flush_ifid, stop_idex, bubble_idex}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Back-to-back RAW: 3 bubbles.
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0); cycle("raw_prod");
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0); wait_issue("raw_cons", n);
    chk("raw.bubbles", 32'(n), 32'd3);
    chk("raw.stall_count", 32'(stall_count), 32'd3);

    // One independent instruction in between: 2 bubbles.
    drive(1, 0, 0, 0, 0, 1, 11, 0, 0); cycle("gap_prod");
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0); cycle("gap_mid");
    drive(1, 11, 1, 0, 0, 0, 0, 0, 0); wait_issue("gap_cons", n);
    chk("gap.bubbles", 32'(n), 32'd2);

    // mem_busy freeze during a RAW stall.
    exp_seq = '{1, 2, 2, 1, 1, 0};
    drive(1, 0, 0, 0, 0, 1, 6, 0, 0); cycle("mem_prod");
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 0, 6, 1, 0, 0, 0, (k == 1 || k == 2));
      cycle("mem_cons");
      chk("mem.cause_seq", 32'(stall_cause), 32'(exp_seq[k]));
    end
    chk("mem.issue_t6", 32'(last_issue), 32'd1);

    // Branch flush during RAW stall; the flushed writer leaves no entry.
    drive(1, 0, 0, 0, 0, 1, 8, 0, 0); cycle("br_prod");
    drive(1, 8, 1, 0, 0, 1, 9, 0, 0); cycle("br_raw");
    drive(1, 8, 1, 0, 0, 1, 9, 1, 0); cycle("br_flush");
    chk("br.stall_cause", 32'(stall_cause), 32'd3);
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0); cycle("br_after");
    chk("br.no_pend_r9", 32'(last_issue), 32'd1);

    // Reading own destination does not self-stall.
    drive(1, 3, 1, 4, 1, 1, 3, 0, 0); cycle("self_dst");
    chk("self.issue", 32'(last_issue), 32'd1);

    // WAW: reader waits on the younger writer.
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0); cycle("waw_w1");
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0); cycle("waw_w2");
    drive(1, 2, 1, 0, 0, 0, 0, 0, 0); wait_issue("waw_rd", n);
    chk("waw.bubbles", 32'(n), 32'd3);

    // Reset in the middle of a stall clears everything at once.
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0); cycle("rst_prod");
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0); cycle("rst_stall");
    #2 reset = 1'b1;
    #1;
    chk("rst_mid.issue", 32'(issue), 32'd1);
    chk("rst_mid.stall_front", 32'(stall_front), 32'd0);
    chk("rst_mid.stall_cause", 32'(stall_cause), 32'd0);
    chk("rst_mid.stall_count", 32'(stall_count), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;

    // Random traffic against the reference.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 9) < 8), $urandom_range(0, NR - 1), $urandom_range(0, 1),
            $urandom_range(0, NR - 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, NR - 1), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0));
      cycle("rand");
    end

    // Saturation of the stall counter.
    for (int k = 0; k < (1 << CW) + 5; k++) begin
      drive(1, $urandom_range(0, NR - 1), 1, 0, 0, 1, 1, 0, 1);
      cycle("sat");
    end
    chk("sat.stall_count", 32'(stall_count), 32'((1 << CW) - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
